// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
//   Shared definitions for the SPI duty-command controller:
//   - state_e        : frame receiver FSM states
//   - FRAME_BITS_DEF : default number of bits in a valid frame
//   - A_MSB/B_MSB/C_MSB : MSB positions of the three duty fields in the frame
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CHECK   = 2'd2,
    WAIT_CS = 2'd3
  } state_e;

  localparam int FRAME_BITS_DEF = 48;

  localparam int A_MSB = 47;
  localparam int B_MSB = 31;
  localparam int C_MSB = 15;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Two-flop synchronizer for one asynchronous input, followed by a
//   registered edge detector. The level output is the delayed synchronized
//   copy, so it lines up in time with the rise/fall pulses.
// Ports:
//   clk     in  : system clock
//   rst_n   in  : asynchronous active-low reset
//   async_i in  : asynchronous input
//   level_o out : synchronized level, aligned with the edge pulses
//   rise_o  out : one-cycle pulse on a synchronized rising edge
//   fall_o  out : one-cycle pulse on a synchronized falling edge
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1]: synchronizer flops; [2]: previous synchronized value.
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level_o = sync_q[2];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_duty_ctrl.sv
// spi_duty_ctrl
//   Receives 48-bit SPI frames (MSB first) in the clk domain, validates
//   them (length, field range, bus timeout) and applies the three duty
//   fields on the next PWM carrier boundary.
// Ports:
//   clk, rst_n              : system clock, asynchronous active-low reset
//   spi_clk, spi_cs, spi_out: raw asynchronous SPI pins (cs active low)
//   pwm_sync                : one-cycle carrier boundary pulse
//   duty_a/b/c              : active duty commands
//   frame_valid             : pulse in the cycle the duty outputs update
//   frame_err               : pulse when a frame is rejected
//   err_cnt                 : saturating rejected-frame count
//   busy                    : high while receiving or checking a frame
module spi_duty_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int                FRAME_BITS  = FRAME_BITS_DEF,
  parameter int                DUTY_W      = 16,
  parameter logic [DUTY_W-1:0] DUTY_MAX    = 16'd50000,
  parameter logic [DUTY_W-1:0] DUTY_RST    = 16'd0,
  parameter int                TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_out,
  input  logic              pwm_sync,
  output logic [DUTY_W-1:0] duty_a,
  output logic [DUTY_W-1:0] duty_b,
  output logic [DUTY_W-1:0] duty_c,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  // Synchronized SPI events
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
  logic dout_lvl, dout_rise_unused, dout_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_i(spi_cs),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .async_i(spi_clk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_dout (
    .clk(clk), .rst_n(rst_n), .async_i(spi_out),
    .level_o(dout_lvl), .rise_o(dout_rise_unused), .fall_o(dout_fall_unused)
  );

  // State
  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [DUTY_W-1:0]       sh_a_q, sh_b_q, sh_c_q, sh_a_d, sh_b_d, sh_c_d;
  logic [DUTY_W-1:0]       duty_a_q, duty_b_q, duty_c_q, duty_a_d, duty_b_d, duty_c_d;
  logic                    pending_q, pending_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  // The cs synchronizer resets to "high", so a cs held low through reset
  // would look like a falling edge once released. Frames are only accepted
  // after the synchronizer has settled and cs has been seen high.
  logic [1:0]              settle_q, settle_d;
  logic                    armed_q, armed_d;

  logic [DUTY_W-1:0] fld_a, fld_b, fld_c;
  logic              frame_ok;
  logic              load;

  assign fld_a = shift_q[A_MSB -: DUTY_W];
  assign fld_b = shift_q[B_MSB -: DUTY_W];
  assign fld_c = shift_q[C_MSB -: DUTY_W];

  assign frame_ok = (bit_cnt_q == 6'(FRAME_BITS)) &&
                    (fld_a <= DUTY_MAX) && (fld_b <= DUTY_MAX) && (fld_c <= DUTY_MAX);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = '0;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    sh_c_d    = sh_c_q;
    duty_a_d  = duty_a_q;
    duty_b_d  = duty_b_q;
    duty_c_d  = duty_c_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    load      = 1'b0;
    settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d   = armed_q | ((settle_q == 2'd3) & cs_lvl);

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        timer_d = timer_q + 1'b1;
        if (sclk_rise) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], dout_lvl};
          bit_cnt_d = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;
          timer_d   = '0;
        end
        if (cs_rise) begin
          state_d = CHECK;
        end else if (!sclk_rise && (timer_q == TMR_W'(TIMEOUT_CYC - 1))) begin
          err_d   = 1'b1;
          state_d = WAIT_CS;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok) load  = 1'b1;
        else          err_d = 1'b1;
      end
      WAIT_CS: begin
        if (cs_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sh_a_d    = fld_a;
      sh_b_d    = fld_b;
      sh_c_d    = fld_c;
      pending_d = 1'b1;
    end

    // A frame validated on the boundary cycle bypasses the shadow wait.
    if (pwm_sync && load) begin
      duty_a_d  = fld_a;
      duty_b_d  = fld_b;
      duty_c_d  = fld_c;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end else if (pwm_sync && pending_q) begin
      duty_a_d  = sh_a_q;
      duty_b_d  = sh_b_q;
      duty_c_d  = sh_c_q;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end

    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      sh_a_q    <= DUTY_RST;
      sh_b_q    <= DUTY_RST;
      sh_c_q    <= DUTY_RST;
      duty_a_q  <= DUTY_RST;
      duty_b_q  <= DUTY_RST;
      duty_c_q  <= DUTY_RST;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      sh_c_q    <= sh_c_d;
      duty_a_q  <= duty_a_d;
      duty_b_q  <= duty_b_d;
      duty_c_q  <= duty_c_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
    end
  end

  assign duty_a      = duty_a_q;
  assign duty_b      = duty_b_q;
  assign duty_c      = duty_c_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = (state_q == SHIFT) || (state_q == CHECK);

endmodule

// File: tb/tb_spi_duty_ctrl.sv
// tb_spi_duty_ctrl
//   Directed self-checking bench for spi_duty_ctrl: bit-banged SPI frames,
//   carrier-boundary pulses and hand-computed expected duty values.
`timescale 1ns/1ps
module tb_spi_duty_ctrl;
  import spi_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_out = 1'b0;
  logic        pwm_sync = 1'b0;
  logic [15:0] duty_a, duty_b, duty_c;
  logic        frame_valid, frame_err, busy;
  logic [7:0]  err_cnt;

  int chk  = 0;
  int pass = 0;
  int fv_pulses = 0;
  int fe_pulses = 0;

  always #5 clk = ~clk;

  spi_duty_ctrl dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_out(spi_out), .pwm_sync(pwm_sync), .duty_a(duty_a), .duty_b(duty_b),
    .duty_c(duty_c), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_cnt(err_cnt), .busy(busy)
  );

  always @(posedge clk) begin
    if (frame_valid === 1'b1) fv_pulses++;
    if (frame_err === 1'b1) fe_pulses++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    spi_cs = 1'b0;
    wait_clks(4);
  endtask

  task automatic send_bits(input logic [63:0] data, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi_out = data[i];
      wait_clks(4);
      spi_clk = 1'b1;
      wait_clks(4);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_end();
    wait_clks(4);
    spi_cs = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_frame(input logic [63:0] data, input int nbits);
    frame_start();
    send_bits(data, nbits - 1, 0);
    frame_end();
  endtask

  task automatic pwm_pulse();
    @(negedge clk);
    pwm_sync = 1'b1;
    @(negedge clk);
    pwm_sync = 1'b0;
    wait_clks(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    chk++; if (duty_a !== 16'd0) $display("FAIL reset_duty_a: got %0d exp 0", duty_a); else pass++;
    chk++; if (duty_b !== 16'd0) $display("FAIL reset_duty_b: got %0d exp 0", duty_b); else pass++;
    chk++; if (duty_c !== 16'd0) $display("FAIL reset_duty_c: got %0d exp 0", duty_c); else pass++;
    chk++; if ({frame_valid, frame_err, busy} !== 3'b000)
      $display("FAIL reset_flags: got %b exp 000", {frame_valid, frame_err, busy}); else pass++;
    chk++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); else pass++;
    rst_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_basic();
    int fv0 = fv_pulses;
    frame_start();
    send_bits(64'h1388_2710_0FA0, 47, 0);
    chk++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b exp 1", busy); else pass++;
    frame_end();
    chk++; if (duty_a !== 16'd0) $display("FAIL basic_hold_a: got %0d exp 0", duty_a); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b exp 0", busy); else pass++;
    wait_clks(20);
    chk++; if (fv_pulses != fv0) $display("FAIL basic_early_valid: got %0d exp %0d", fv_pulses, fv0); else pass++;
    pwm_pulse();
    chk++; if (duty_a !== 16'd5000) $display("FAIL basic_duty_a: got %0d exp 5000", duty_a); else pass++;
    chk++; if (duty_b !== 16'd10000) $display("FAIL basic_duty_b: got %0d exp 10000", duty_b); else pass++;
    chk++; if (duty_c !== 16'd4000) $display("FAIL basic_duty_c: got %0d exp 4000", duty_c); else pass++;
    chk++; if (fv_pulses != fv0 + 1) $display("FAIL basic_valid_pulses: got %0d exp %0d", fv_pulses, fv0 + 1); else pass++;
  endtask

  task automatic test_length();
    int fe0 = fe_pulses;
    int fv0 = fv_pulses;
    send_frame(64'h0000_1388_2710_0FA0 >> 1, 47);
    send_frame(64'h0000_1388_2710_0FA0, 49);
    chk++; if (fe_pulses != fe0 + 2) $display("FAIL len_err_pulses: got %0d exp %0d", fe_pulses, fe0 + 2); else pass++;
    chk++; if (err_cnt !== 8'd2) $display("FAIL len_err_cnt: got %0d exp 2", err_cnt); else pass++;
    pwm_pulse();
    chk++; if (duty_a !== 16'd5000) $display("FAIL len_duty_a: got %0d exp 5000", duty_a); else pass++;
    chk++; if (fv_pulses != fv0) $display("FAIL len_no_valid: got %0d exp %0d", fv_pulses, fv0); else pass++;
  endtask

  task automatic test_range();
    int fv0 = fv_pulses;
    send_frame(64'h0001_C351_0001, 48);
    chk++; if (err_cnt !== 8'd3) $display("FAIL range_err_cnt: got %0d exp 3", err_cnt); else pass++;
    chk++; if (dut.pending_q !== 1'b0) $display("FAIL range_pending: got %b exp 0", dut.pending_q); else pass++;
    pwm_pulse();
    chk++; if (duty_b !== 16'd10000) $display("FAIL range_duty_b: got %0d exp 10000", duty_b); else pass++;
    chk++; if (fv_pulses != fv0) $display("FAIL range_no_valid: got %0d exp %0d", fv_pulses, fv0); else pass++;
    // Exactly DUTY_MAX is legal.
    send_frame(64'hC350_C350_0000, 48);
    pwm_pulse();
    chk++; if (duty_a !== 16'd50000) $display("FAIL range_max_a: got %0d exp 50000", duty_a); else pass++;
    chk++; if (duty_b !== 16'd50000) $display("FAIL range_max_b: got %0d exp 50000", duty_b); else pass++;
    chk++; if (err_cnt !== 8'd3) $display("FAIL range_max_err: got %0d exp 3", err_cnt); else pass++;
  endtask

  task automatic test_back_to_back();
    int fv0 = fv_pulses;
    send_frame(64'h0064_0000_0000, 48);
    send_frame(64'h00C8_0000_0000, 48);
    pwm_pulse();
    pwm_pulse();
    chk++; if (duty_a !== 16'd200) $display("FAIL b2b_duty_a: got %0d exp 200", duty_a); else pass++;
    chk++; if (fv_pulses != fv0 + 1) $display("FAIL b2b_valid_pulses: got %0d exp %0d", fv_pulses, fv0 + 1); else pass++;
  endtask

  task automatic test_collision();
    int fv0 = fv_pulses;
    bit hit = 1'b0;
    frame_start();
    send_bits(64'h04D2_0929_0D80, 47, 0);
    wait_clks(4);
    spi_cs = 1'b1;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge clk);
      if (dut.state_q == CHECK) begin
        pwm_sync = 1'b1;
        hit = 1'b1;
      end
    end
    chk++; if (!hit) $display("FAIL coll_check_seen: got no CHECK exp CHECK within 16 cycles"); else pass++;
    @(negedge clk);
    pwm_sync = 1'b0;
    chk++; if (duty_a !== 16'd1234) $display("FAIL coll_duty_a: got %0d exp 1234", duty_a); else pass++;
    chk++; if (duty_c !== 16'd3456) $display("FAIL coll_duty_c: got %0d exp 3456", duty_c); else pass++;
    chk++; if (dut.pending_q !== 1'b0) $display("FAIL coll_pending: got %b exp 0", dut.pending_q); else pass++;
    pwm_pulse();
    chk++; if (fv_pulses != fv0 + 1) $display("FAIL coll_valid_pulses: got %0d exp %0d", fv_pulses, fv0 + 1); else pass++;
  endtask

  task automatic test_timeout();
    int fe0 = fe_pulses;
    frame_start();
    send_bits(64'h0000_0000_0000_03FF, 9, 0);
    wait_clks(4096 + 20);
    chk++; if (fe_pulses != fe0 + 1) $display("FAIL tmo_err_pulse: got %0d exp %0d", fe_pulses, fe0 + 1); else pass++;
    chk++; if (dut.state_q !== WAIT_CS) $display("FAIL tmo_state: got %0d exp %0d", dut.state_q, WAIT_CS); else pass++;
    chk++; if (err_cnt !== 8'd4) $display("FAIL tmo_err_cnt: got %0d exp 4", err_cnt); else pass++;
    spi_cs = 1'b1;
    wait_clks(10);
    chk++; if (dut.state_q !== IDLE) $display("FAIL tmo_idle: got %0d exp %0d", dut.state_q, IDLE); else pass++;
    send_frame(64'h0111_0222_0333, 48);
    pwm_pulse();
    chk++; if (duty_a !== 16'd273) $display("FAIL tmo_next_a: got %0d exp 273", duty_a); else pass++;
    chk++; if (duty_b !== 16'd546) $display("FAIL tmo_next_b: got %0d exp 546", duty_b); else pass++;
    chk++; if (duty_c !== 16'd819) $display("FAIL tmo_next_c: got %0d exp 819", duty_c); else pass++;
  endtask

  task automatic test_reset_mid();
    int fe0;
    int fv0;
    frame_start();
    send_bits(64'h2222_2222_2222, 47, 28);
    rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    chk++; if (duty_a !== 16'd0) $display("FAIL rstmid_duty_a: got %0d exp 0", duty_a); else pass++;
    chk++; if (err_cnt !== 8'd0) $display("FAIL rstmid_err_cnt: got %0d exp 0", err_cnt); else pass++;
    fe0 = fe_pulses;
    fv0 = fv_pulses;
    send_bits(64'h2222_2222_2222, 27, 0);
    chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else pass++;
    frame_end();
    pwm_pulse();
    chk++; if (fe_pulses != fe0) $display("FAIL rstmid_no_err: got %0d exp %0d", fe_pulses, fe0); else pass++;
    chk++; if (fv_pulses != fv0) $display("FAIL rstmid_no_valid: got %0d exp %0d", fv_pulses, fv0); else pass++;
    chk++; if (duty_b !== 16'd0) $display("FAIL rstmid_duty_b: got %0d exp 0", duty_b); else pass++;
    send_frame(64'h0005_0006_0007, 48);
    pwm_pulse();
    chk++; if (duty_c !== 16'd7) $display("FAIL rstmid_new_c: got %0d exp 7", duty_c); else pass++;
  endtask

  task automatic test_err_sat();
    int fe0 = fe_pulses;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      spi_cs = 1'b0;
      wait_clks(6);
      spi_cs = 1'b1;
      wait_clks(8);
      if (i == 253) begin
        chk++; if (err_cnt !== 8'd254) $display("FAIL sat_err_254: got %0d exp 254", err_cnt); else pass++;
      end
    end
    chk++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt: got %0d exp 255", err_cnt); else pass++;
    chk++; if (fe_pulses != fe0 + 256) $display("FAIL sat_err_pulses: got %0d exp %0d", fe_pulses, fe0 + 256); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_length();
    test_range();
    test_back_to_back();
    test_collision();
    test_timeout();
    test_reset_mid();
    test_err_sat();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
